// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register-file write master merging ALU results with buffered load responses
module regfile_writeback #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          aluValid,
  input  logic [ADDR_W-1:0]             aluRd,
  input  logic [DATA_W-1:0]             aluData,
  input  logic                          ldValid,
  output logic                          ldReady,
  input  logic [ADDR_W-1:0]             ldRd,
  input  logic [2:0]                    ldFunct3,
  input  logic [DATA_W-1:0]             ldData,
  output logic                          writeEnable,
  output logic [ADDR_W-1:0]             writeAddr,
  output logic [DATA_W-1:0]             writeData,
  input  logic [ADDR_W-1:0]             chkAddr1,
  input  logic [ADDR_W-1:0]             chkAddr2,
  output logic                          chkBusy1,
  output logic                          chkBusy2,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          stallReq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_rd_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              push, pop;
  logic [DATA_W-1:0] ext_data;
  logic [FIFO_DEPTH-1:0] slot_valid;

  always_comb begin
    ext_data = ldData;
    case (ldFunct3)
      3'b000:  ext_data = {{(DATA_W-8){ldData[7]}},   ldData[7:0]};
      3'b001:  ext_data = {{(DATA_W-16){ldData[15]}}, ldData[15:0]};
      3'b010:  ext_data = {{(DATA_W-32){ldData[31]}}, ldData[31:0]};
      3'b100:  ext_data = {{(DATA_W-8){1'b0}},        ldData[7:0]};
      3'b101:  ext_data = {{(DATA_W-16){1'b0}},       ldData[15:0]};
      3'b110:  ext_data = {{(DATA_W-32){1'b0}},       ldData[31:0]};
      default: ext_data = ldData;
    endcase
  end

  // No pass-through when full: acceptance depends only on the registered count.
  assign ldReady = reset && (count_q < CNT_W'(FIFO_DEPTH));
  assign push    = ldValid && ldReady;
  assign pop     = !aluValid && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (!push && pop) count_d = count_q - CNT_W'(1);
    if (aluValid) begin
      we_d    = (aluRd != '0);
      waddr_d = aluRd;
      wdata_d = aluData;
    end else if (pop) begin
      we_d    = (fifo_rd_q[rd_ptr_q] != '0);
      waddr_d = fifo_rd_q[rd_ptr_q];
      wdata_d = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Storage needs no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ext_data;
      fifo_rd_q[wr_ptr_q]   <= ldRd;
    end
  end

  always_comb begin
    slot_valid = '0;
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      slot_valid[j] = ({1'b0, PTR_W'(j) - rd_ptr_q} < count_q);
    end
  end

  function automatic logic busy_for(input logic [ADDR_W-1:0] addr);
    logic hit;
    hit = we_q && (waddr_q == addr);
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      if (slot_valid[j] && (fifo_rd_q[j] == addr)) hit = 1'b1;
    end
    return (addr != '0) && hit;
  endfunction

  assign chkBusy1    = busy_for(chkAddr1);
  assign chkBusy2    = busy_for(chkAddr2);
  assign writeEnable = we_q;
  assign writeAddr   = waddr_q;
  assign writeData   = wdata_q;
  assign fifoCount   = count_q;
  assign stallReq    = (count_q == CNT_W'(FIFO_DEPTH));

endmodule
